// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM arbiter on the unified single-port SRAM.
// Default widths, read-owner encoding and the muxed SRAM request.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  typedef struct packed {
    logic                    we;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wdata;
    logic [DATA_W_DEF/8-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive denied fetch cycles; raises o_if_prio once the count hits STARVE_MAX.
// Registered count, combinational flag; clears on any fetch grant or when fetch stops asking.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_if_req,
  input  logic i_if_gnt,
  output logic o_if_prio
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_if_req && !i_if_gnt) begin
      if (r_cnt != SW'(STARVE_MAX)) begin
        r_cnt <= r_cnt + SW'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_if_prio = (r_cnt == SW'(STARVE_MAX));

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port SRAM between fetch and data ports, one access per cycle.
// Grants are combinational; read data returns to its owner one cycle after the grant.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wmask,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_cs,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    conflict_cnt
);

  logic       w_if_prio;
  logic       w_if_gnt;
  logic       w_dm_gnt;
  logic       w_both;
  mem_req_t   w_req;
  owner_e     r_owner;
  owner_e     w_owner_nxt;
  logic [CNT_W-1:0] r_conf;

  assign w_both = if_req & dm_req;

  // Data wins a conflict unless fetch has been starved long enough.
  assign w_if_gnt = rst & if_req & (~dm_req | w_if_prio);
  assign w_dm_gnt = rst & dm_req & ~w_if_gnt;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .i_if_req  (if_req),
    .i_if_gnt  (w_if_gnt),
    .o_if_prio (w_if_prio)
  );

  always_comb begin
    w_req = '0;
    if (w_if_gnt) begin
      w_req.addr = if_addr;
    end else if (w_dm_gnt) begin
      w_req.we   = dm_we;
      w_req.addr = dm_addr;
      if (dm_we) begin
        w_req.wdata = dm_wdata;
        w_req.wmask = dm_wmask;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign dm_gnt    = w_dm_gnt;
  assign mem_cs    = w_if_gnt | w_dm_gnt;
  assign mem_we    = w_req.we;
  assign mem_addr  = w_req.addr;
  assign mem_wdata = w_req.wdata;
  assign mem_wmask = w_req.wmask;

  // Writes leave no owner: the SRAM returns nothing worth routing.
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_if_gnt) begin
      w_owner_nxt = OWN_IF;
    end else if (w_dm_gnt && !dm_we) begin
      w_owner_nxt = OWN_DM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Gating with rst drops a return that lands while reset is held.
  assign if_rvalid = rst & (r_owner == OWN_IF);
  assign dm_rvalid = rst & (r_owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_conf <= '0;
    end else if (w_both && (r_conf != '1)) begin
      r_conf <= r_conf + CNT_W'(1);
    end
  end

  assign conflict_cnt = r_conf;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed table, starvation/saturation sequence, randomized traffic.
module tb_imem_dmem_arbiter;

  localparam int AW   = 15;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [3:0]    dm_wmask;

  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_cs, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wmask;
  logic [15:0]   conflict_cnt;

  logic          u2_if_gnt, u2_if_rvalid, u2_dm_gnt, u2_dm_rvalid, u2_mem_cs, u2_mem_we;
  logic [DW-1:0] u2_if_rdata, u2_dm_rdata, u2_mem_wdata;
  logic [AW-1:0] u2_mem_addr;
  logic [3:0]    u2_mem_wmask;
  logic [3:0]    conflict_cnt4;

  imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(u2_if_gnt), .if_rvalid(u2_if_rvalid), .if_rdata(u2_if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wmask(dm_wmask),
    .dm_gnt(u2_dm_gnt), .dm_rvalid(u2_dm_rvalid), .dm_rdata(u2_dm_rdata),
    .mem_cs(u2_mem_cs), .mem_we(u2_mem_we), .mem_addr(u2_mem_addr), .mem_wdata(u2_mem_wdata),
    .mem_wmask(u2_mem_wmask), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt4)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: denied-fetch streak, conflicts seen since reset, and who
  // the SRAM answers this cycle (0 nobody, 1 fetch, 2 data).
  int m_starve, m_conf, m_ret;
  bit e_ifg, e_dmg;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic half_check(input bit en);
    bit ifv, dmv;
    #4;
    e_ifg = 1'b0;
    e_dmg = 1'b0;
    if (rst === 1'b1) begin
      if (if_req && dm_req) begin
        e_ifg = (m_starve >= SMAX);
        e_dmg = !e_ifg;
      end else begin
        e_ifg = if_req;
        e_dmg = dm_req;
      end
    end
    ifv = (rst === 1'b1) && (m_ret == 1);
    dmv = (rst === 1'b1) && (m_ret == 2);
    if (en) begin
      chk("if_gnt", if_gnt, e_ifg);
      chk("dm_gnt", dm_gnt, e_dmg);
      chk("mem_cs", mem_cs, e_ifg | e_dmg);
      chk("mem_we", mem_we, e_dmg & dm_we);
      chk("mem_addr", mem_addr, e_ifg ? if_addr : (e_dmg ? dm_addr : '0));
      chk("mem_wmask", mem_wmask, (e_dmg && dm_we) ? dm_wmask : 4'h0);
      if (e_dmg && dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
      chk("if_rvalid", if_rvalid, ifv);
      chk("dm_rvalid", dm_rvalid, dmv);
      chk("if_rdata", if_rdata, ifv ? mem_rdata : '0);
      chk("dm_rdata", dm_rdata, dmv ? mem_rdata : '0);
      chk("conflict_cnt", conflict_cnt, m_conf);
      chk("conflict_cnt4", conflict_cnt4, (m_conf > 15) ? 15 : m_conf);
      chk("u2_gnt", {u2_if_gnt, u2_dm_gnt}, {e_ifg, e_dmg});
    end
  endtask

  task automatic finish_edge();
    @(posedge clk);
    if (rst !== 1'b1) begin
      m_starve = 0;
      m_conf   = 0;
      m_ret    = 0;
    end else begin
      m_ret = e_ifg ? 1 : ((e_dmg && !dm_we) ? 2 : 0);
      if (if_req && !e_ifg) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      else                  m_starve = 0;
      if (if_req && dm_req) m_conf = (m_conf < 65535) ? m_conf + 1 : 65535;
    end
    #1;
  endtask

  typedef struct {
    bit            rst, ifr;
    logic [AW-1:0] ifa;
    bit            dmr, we;
    logic [AW-1:0] dma;
    logic [DW-1:0] wd;
    logic [3:0]    wm;
    logic [DW-1:0] rd;
    bit            eifg, edmg, eifv, edmv;
    logic [DW-1:0] erd;
    int            econf;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(bit r, bit ifr, int ifa, bit dmr, bit we, int dma, logic [DW-1:0] wd,
                              logic [3:0] wm, logic [DW-1:0] rd, bit eifg, bit edmg, bit eifv,
                              bit edmv, logic [DW-1:0] erd, int econf);
    vec_t v;
    v.rst = r;  v.ifr = ifr; v.ifa = AW'(ifa); v.dmr = dmr; v.we = we; v.dma = AW'(dma);
    v.wd = wd;  v.wm = wm;   v.rd = rd;
    v.eifg = eifg; v.edmg = edmg; v.eifv = eifv; v.edmv = edmv; v.erd = erd; v.econf = econf;
    return v;
  endfunction

  task automatic drive(input bit r, input bit ifr, input logic [AW-1:0] ifa, input bit dmr,
                       input bit we, input logic [AW-1:0] dma, input logic [DW-1:0] wd,
                       input logic [3:0] wm, input logic [DW-1:0] rd);
    rst = r; if_req = ifr; if_addr = ifa; dm_req = dmr; dm_we = we;
    dm_addr = dma; dm_wdata = wd; dm_wmask = wm; mem_rdata = rd;
  endtask

  initial begin
    //            rst ifr ifa dmr we dma wdata         wm    rdata         ifg dmg ifv dmv erd           conf
    tbl[0]  = mk(0, 1, 0,  1, 0, 0,    32'h0,        4'h0, 32'h0,        0, 0, 0, 0, 32'h0,        0);
    tbl[1]  = mk(1, 1, 0,  0, 0, 0,    32'h0,        4'h0, 32'h0,        1, 0, 0, 0, 32'h0,        0);
    tbl[2]  = mk(1, 1, 1,  0, 0, 0,    32'h0,        4'h0, 32'h11,       1, 0, 1, 0, 32'h11,       0);
    tbl[3]  = mk(1, 1, 2,  0, 0, 0,    32'h0,        4'h0, 32'h22,       1, 0, 1, 0, 32'h22,       0);
    tbl[4]  = mk(1, 0, 0,  0, 0, 0,    32'h0,        4'h0, 32'h33,       0, 0, 1, 0, 32'h33,       0);
    tbl[5]  = mk(1, 0, 0,  1, 1, 16,   32'hDEADBEEF, 4'hF, 32'h0,        0, 1, 0, 0, 32'h0,        0);
    tbl[6]  = mk(1, 0, 0,  1, 0, 16,   32'h0,        4'h0, 32'h0,        0, 1, 0, 0, 32'h0,        0);
    tbl[7]  = mk(1, 0, 0,  0, 0, 0,    32'h0,        4'h0, 32'hDEADBEEF, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    tbl[8]  = mk(1, 1, 5,  0, 0, 0,    32'h0,        4'h0, 32'h0,        1, 0, 0, 0, 32'h0,        0);
    tbl[9]  = mk(1, 0, 0,  1, 0, 6,    32'h0,        4'h0, 32'hA,        0, 1, 1, 0, 32'hA,        0);
    tbl[10] = mk(1, 0, 0,  0, 0, 0,    32'h0,        4'h0, 32'hB,        0, 0, 0, 1, 32'hB,        0);
    tbl[11] = mk(1, 1, 7,  1, 0, 8,    32'h0,        4'h0, 32'h10B,      0, 1, 0, 0, 32'h0,        0);
    tbl[12] = mk(1, 1, 7,  1, 0, 8,    32'h0,        4'h0, 32'h10C,      0, 1, 0, 1, 32'h10C,      1);
    tbl[13] = mk(1, 1, 7,  1, 0, 8,    32'h0,        4'h0, 32'h10D,      0, 1, 0, 1, 32'h10D,      2);
    tbl[14] = mk(1, 1, 7,  1, 0, 8,    32'h0,        4'h0, 32'h10E,      0, 1, 0, 1, 32'h10E,      3);
    tbl[15] = mk(1, 1, 7,  1, 0, 8,    32'h0,        4'h0, 32'h10F,      1, 0, 0, 1, 32'h10F,      4);
    tbl[16] = mk(1, 1, 7,  1, 0, 8,    32'h0,        4'h0, 32'h110,      0, 1, 1, 0, 32'h110,      5);
    tbl[17] = mk(1, 0, 0,  0, 0, 0,    32'h0,        4'h0, 32'h111,      0, 0, 0, 1, 32'h111,      6);
    tbl[18] = mk(1, 0, 0,  1, 0, 9,    32'h0,        4'h0, 32'h0,        0, 1, 0, 0, 32'h0,        6);
    tbl[19] = mk(0, 1, 3,  1, 0, 9,    32'h0,        4'h0, 32'h55,       0, 0, 0, 0, 32'h0,        6);
    tbl[20] = mk(1, 1, 3,  0, 0, 0,    32'h0,        4'h0, 32'h0,        1, 0, 0, 0, 32'h0,        0);
    tbl[21] = mk(1, 0, 0,  0, 0, 0,    32'h0,        4'h0, 32'h77,       0, 0, 1, 0, 32'h77,       0);

    m_starve = 0; m_conf = 0; m_ret = 0;
    drive(0, 0, '0, 0, 0, '0, '0, 4'h0, '0);
    @(posedge clk);
    #1;
    half_check(0); finish_edge();
    half_check(0); finish_edge();

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].rst, tbl[i].ifr, tbl[i].ifa, tbl[i].dmr, tbl[i].we, tbl[i].dma,
            tbl[i].wd, tbl[i].wm, tbl[i].rd);
      half_check(1);
      chk($sformatf("tbl%0d_gnt", i), {if_gnt, dm_gnt}, {tbl[i].eifg, tbl[i].edmg});
      chk($sformatf("tbl%0d_rvalid", i), {if_rvalid, dm_rvalid}, {tbl[i].eifv, tbl[i].edmv});
      if (tbl[i].eifv) chk($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].erd);
      if (tbl[i].edmv) chk($sformatf("tbl%0d_dm_rdata", i), dm_rdata, tbl[i].erd);
      chk($sformatf("tbl%0d_conf", i), conflict_cnt, tbl[i].econf);
      finish_edge();
    end

    // Twenty back-to-back conflicts: fetch wins every fifth cycle, the 4-bit counter pins at 15.
    drive(0, 0, '0, 0, 0, '0, '0, 4'h0, '0);
    half_check(1); finish_edge();
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, AW'(i), 1, 0, AW'(100 + i), '0, 4'h0, DW'(i));
      half_check(1);
      chk($sformatf("seq%0d_if_gnt", i), if_gnt, (i % 5) == 4);
      chk($sformatf("seq%0d_dm_gnt", i), dm_gnt, (i % 5) != 4);
      finish_edge();
    end
    drive(1, 0, '0, 0, 0, '0, '0, 4'h0, '0);
    half_check(1);
    chk("sat_cnt4", conflict_cnt4, 4'hF);
    chk("cnt16_after_20", conflict_cnt, 16'd20);
    finish_edge();

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0, AW'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, AW'($urandom),
            $urandom, 4'($urandom), $urandom);
      half_check(1);
      finish_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Arbitrates one shared single-port synchronous SRAM between the CPU's instruction-fetch (IF) port and data-memory (MEM) port, one access per cycle.
- Sits between the CPU pipeline and the unified memory macro.
- Data accesses have fixed priority. A starvation counter guarantees that fetch makes forward progress.
- Also routes 1-cycle-latency read data back to the correct requester and keeps a conflict counter for performance analysis.

Parameters:
- ADDR_W, 15: word address width (32768 words).
- DATA_W, 32: data word width.
- STARVE_MAX, 4: consecutive denied IF cycles after which IF wins the next conflict.
- CNT_W, 16: width of the conflict counter (saturating).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- if_req  in  1  fetch request, held until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  if_rdata valid.
- if_rdata  out  DATA_W  fetch read data.
- dm_req  in  1  data request, held until dm_gnt.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  write data.
- dm_wmask  in  DATA_W/8  byte write enables.
- dm_gnt  out  1  data access accepted this cycle.
- dm_rvalid  out  1  dm_rdata valid (reads only).
- dm_rdata  out  DATA_W  data read data.
- mem_cs  out  1  SRAM chip select.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_wmask  out  DATA_W/8  SRAM byte mask.
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after a read with cs.
- conflict_cnt  out  CNT_W  count of cycles where both requests were active.

Behaviour:
- **Grant logic (combinational in the request cycle):**
  - Only one requester: it is granted.
  - Both request: dm wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
  - Neither: no grant, mem_cs=0.
- At most one of if_gnt/dm_gnt is high in any cycle.
- mem_cs = if_gnt | dm_gnt.
- mem_we = dm_gnt & dm_we; mem_we is never asserted for an IF grant.
- mem_addr, mem_wdata and mem_wmask are muxed from the granted port. When idle they hold 0; mem_wmask is 0 for reads.
- **Owner register:** rd_owner ∈ {NONE, IF, DM}, registered each cycle.
  - Becomes IF on an IF grant, DM on a DM read grant.
  - Becomes NONE on a DM write grant or when there is no grant.
- **Read return:** one cycle after a read grant, the owner's rvalid=1 and its rdata=mem_rdata. The non-owner's rvalid=0 and its rdata=0.
  - Back-to-back reads from alternating owners return in grant order, one per cycle.
- **Writes:** complete on dm_gnt. They produce no rvalid.
- **starve_cnt (width clog2(STARVE_MAX+1)):**
  - Increments when if_req=1 and if_gnt=0.
  - Clears to 0 on if_gnt or when if_req=0.
  - Never exceeds STARVE_MAX.
- **conflict_cnt:** increments when if_req & dm_req; saturates at all-ones.
- **Reset (rst==0 at an edge):**
  - rd_owner=NONE, starve_cnt=0, conflict_cnt=0.
  - if_rvalid=dm_rvalid=0; if_rdata=dm_rdata=0.
- **Grant outputs during reset:** gnt outputs are forced 0 and mem_cs=0 while rst==0.
- **Reset mid-operation:** a read granted in the cycle reset asserts returns no rvalid, and its data is discarded.
- **Protocol violations:** a requester dropping req before gnt is tolerated (no grant issued). Address or data changing while req is held is taken as sampled at grant.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the owner_e enum (OWN_NONE, OWN_IF, OWN_DM);
  - the ADDR_W/DATA_W defaults;
  - the mem_req_t struct {we, addr, wdata, wmask}.
- One natural sub-module, arb_starve_ctr: the starvation counter plus the priority-override flag.
- The grant mux and return routing stay in the top module.

Test Plan:
- **IF only:** if_req=1 at addresses 0,1,2 on consecutive cycles; mem_rdata=0x11,0x22,0x33 → if_gnt=1 every cycle, if_rvalid one cycle later with data 0x11/0x22/0x33, dm_rvalid=0.
- **DM write then read:** dm_we=1, addr 0x10, wdata 0xDEADBEEF, mask 4'hF → mem_we=1, no rvalid. Next, a read of 0x10 with mem_rdata=0xDEADBEEF → dm_rvalid=1 with 0xDEADBEEF the next cycle.
- **Conflict priority:** both requesting continuously for 6 cycles (STARVE_MAX=4) → grant sequence DM,DM,DM,DM,IF,DM; conflict_cnt=6; starve_cnt returns to 0 after the IF grant.
- **Interleaved return routing:** grant IF read (data 0xA), then DM read (data 0xB) → cycle+1 if_rvalid with 0xA; cycle+2 dm_rvalid with 0xB; never both valid.
- **Reset mid-read:** DM read granted, rst=0 on the next edge → no dm_rvalid, counters 0, mem_cs=0 while rst=0. After release, IF-only traffic resumes normally.
- **Counter saturation:** CNT_W=4, 20 conflict cycles → conflict_cnt holds 15.
